// File: rtl/series_adder_arbiter.sv
// Round-robin arbiter that lends one series-adder streamer to N requesters,
// one outstanding job at a time, with a bounded wait for each result.
`timescale 1ns/1ps
module series_adder_arbiter #(
    parameter int N       = 4,
    parameter int M       = 32,
    parameter int TIMEOUT = 128,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1,
    localparam int DW     = M * 32
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [N-1:0]      req_vld_i,
    input  logic [N*DW-1:0]   req_data_i,
    output logic [N-1:0]      req_rdy_o,
    output logic [N-1:0]      resp_vld_o,
    output logic [39:0]       resp_data_o,
    output logic [IDW-1:0]    resp_id_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              adder_data_vld_o,
    output logic [DW-1:0]     adder_data_o,
    input  logic              adder_data_rdy_i,
    input  logic [39:0]       adder_result_i,
    input  logic              adder_result_vld_i
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0] gnt_id_reg, gnt_id_next;
    logic [CW-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [N-1:0]   req_rdy_reg, req_rdy_next;
    logic [N-1:0]   resp_vld_reg, resp_vld_next;
    logic [39:0]    resp_data_reg, resp_data_next;
    logic [IDW-1:0] resp_id_reg, resp_id_next;
    logic           err_reg, err_next;
    logic           data_vld_reg, data_vld_next;
    logic [DW-1:0]  adder_data_reg, adder_data_next;

    logic [DW-1:0]  req_slice [N];
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] scan_idx;

    // (a + b) mod N for 0 <= b < N; collapses to constant 0 when N is 1
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign req_slice[gi] = req_data_i[gi*DW +: DW];
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            scan_idx = wrap_add(rr_ptr_reg, i);
            if (req_vld_i[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        gnt_id_next     = gnt_id_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        req_rdy_next    = '0;
        resp_vld_next   = '0;
        err_next        = 1'b0;
        data_vld_next   = 1'b0;
        resp_data_next  = resp_data_reg;
        resp_id_next    = resp_id_reg;
        adder_data_next = adder_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (adder_data_rdy_i && win_found) begin
                    gnt_id_next     = win_id;
                    adder_data_next = req_slice[win_id];
                    req_rdy_next    = ONE << win_id;
                    data_vld_next   = 1'b1;
                    tmo_cnt_next    = '0;
                    state_next      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_cnt_next = tmo_cnt_reg + CW'(1);
                // A result on the final timeout cycle still counts as a result
                if (adder_result_vld_i) begin
                    resp_data_next = adder_result_i;
                    resp_id_next   = gnt_id_reg;
                    resp_vld_next  = ONE << gnt_id_reg;
                    rr_ptr_next    = wrap_add(gnt_id_reg, 1);
                    state_next     = ST_IDLE;
                end else if (tmo_cnt_reg == CW'(TIMEOUT - 1)) begin
                    err_next     = 1'b1;
                    resp_id_next = gnt_id_reg;
                    rr_ptr_next  = wrap_add(gnt_id_reg, 1);
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            gnt_id_reg     <= '0;
            tmo_cnt_reg    <= '0;
            req_rdy_reg    <= '0;
            resp_vld_reg   <= '0;
            resp_data_reg  <= '0;
            resp_id_reg    <= '0;
            err_reg        <= 1'b0;
            data_vld_reg   <= 1'b0;
            adder_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            gnt_id_reg     <= gnt_id_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            req_rdy_reg    <= req_rdy_next;
            resp_vld_reg   <= resp_vld_next;
            resp_data_reg  <= resp_data_next;
            resp_id_reg    <= resp_id_next;
            err_reg        <= err_next;
            data_vld_reg   <= data_vld_next;
            adder_data_reg <= adder_data_next;
        end
    end

    assign req_rdy_o        = req_rdy_reg;
    assign resp_vld_o       = resp_vld_reg;
    assign resp_data_o      = resp_data_reg;
    assign resp_id_o        = resp_id_reg;
    assign err_o            = err_reg;
    assign busy_o           = (state_reg == ST_WAIT);
    assign adder_data_vld_o = data_vld_reg;
    assign adder_data_o     = adder_data_reg;

endmodule

// File: doc/series_adder_arbiter.md
SERIES_ADDER_ARBITER -- requirements
Module: series_adder_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one series-adder data streamer.
REQ-002 Parameter M, default 32, operands per job; each operand is 32 bits.
REQ-003 Parameter TIMEOUT, default 128, maximum cycles to wait for a streamer result.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_p  input  1  synchronous, active-high reset.
REQ-006 req_vld_i  input  N  per-requester job request; held high until the matching req_rdy_o bit is seen.
REQ-007 req_data_i  input  N*M*32  per-requester packed operands; slice k is bits [k*M*32 +: M*32], held stable while req_vld_i[k]=1.
REQ-008 req_rdy_o  output  N  one-hot, one-cycle pulse; job of that requester accepted.
REQ-009 resp_vld_o  output  N  one-hot, one-cycle pulse; result for that requester is on resp_data_o.
REQ-010 resp_data_o  output  40  shared result bus, valid when any resp_vld_o bit is high.
REQ-011 resp_id_o  output  clog2(N)  index of the requester owning resp_data_o or err_o.
REQ-012 err_o  output  1  one-cycle pulse; the granted job timed out.
REQ-013 busy_o  output  1  high whenever the state is not IDLE.
REQ-014 adder_data_vld_o  output  1  one-cycle job strobe to the streamer.
REQ-015 adder_data_o  output  M*32  operands to the streamer, held stable from the strobe until return to IDLE.
REQ-016 adder_data_rdy_i  input  1  streamer idle/ready.
REQ-017 adder_result_i  input  40  streamer sum.
REQ-018 adder_result_vld_i  input  1  streamer sum valid, one cycle.

Function
REQ-019 The arbiter SHALL use two states: IDLE and WAIT.
REQ-020 In IDLE, with any req_vld_i bit high and adder_data_rdy_i=1, the winner SHALL be the first requester with req_vld_i high, searching upward from rr_ptr modulo N.
REQ-021 On that edge the arbiter SHALL latch the winner's slice into adder_data_o and its index into gnt_id, and SHALL register req_rdy_o[gnt]=1 and adder_data_vld_o=1 for exactly one cycle.
REQ-022 On that same edge the state SHALL move to WAIT and the timeout counter SHALL clear to 0.
REQ-023 In IDLE, with adder_data_rdy_i=0 or no request, the arbiter SHALL issue no grant and stay in IDLE.
REQ-024 In WAIT, the timeout counter SHALL increment every cycle.
REQ-025 In WAIT, on adder_result_vld_i=1 the arbiter SHALL register resp_data_o=adder_result_i, resp_id_o=gnt_id and resp_vld_o[gnt_id]=1 for one cycle.
REQ-026 In that same case rr_ptr SHALL become (gnt_id+1) mod N and the state SHALL return to IDLE.
REQ-027 In WAIT, when the counter reaches TIMEOUT-1 without a result, the arbiter SHALL pulse err_o with resp_id_o=gnt_id, assert no resp_vld_o bit, set rr_ptr=(gnt_id+1) mod N and return to IDLE.
REQ-028 When a result and the timeout limit occur in the same cycle, the result SHALL win and err_o SHALL stay 0.
REQ-029 An adder_result_vld_i arriving in IDLE, such as a late result after a timeout, SHALL be ignored.
REQ-030 Exactly one job SHALL be outstanding at a time; new grants SHALL occur only in IDLE.
REQ-031 Minimum request-to-request service time SHALL be streamer latency + 2 cycles.
REQ-032 req_rdy_o, resp_vld_o and err_o SHALL each be at most one-hot and never high for two consecutive cycles for the same job.
REQ-033 Arithmetic on rr_ptr SHALL wrap modulo N; for N=1 rr_ptr SHALL be constant 0.
REQ-034 Round-robin SHALL guarantee that a continuously requesting requester is granted within N jobs.

Reset
REQ-035 While rst_p=1 at a clock edge, the state SHALL become IDLE and rr_ptr, gnt_id and the timeout counter SHALL become 0.
REQ-036 While rst_p=1 at a clock edge, req_rdy_o, resp_vld_o, err_o, adder_data_vld_o, resp_data_o, resp_id_o and adder_data_o SHALL all become 0.
REQ-037 Reset SHALL take priority over all other state updates, and an in-flight job SHALL be discarded without a response.

Verification
REQ-038 Single job: requester 2 has operands 1..32 and the streamer model returns 528 -> req_rdy_o=4'b0100 for one cycle, then resp_vld_o=4'b0100, resp_data_o=528, resp_id_o=2.
REQ-039 Contention: all four requesters high continuously from reset -> grant order is 0,1,2,3,0, with exactly one outstanding job at a time.
REQ-040 Streamer busy: adder_data_rdy_i=0 for 10 cycles with req_vld_i[1]=1 -> no grant until the cycle after ready rises, then req_rdy_o[1] pulses.
REQ-041 Timeout: the streamer model never answers -> err_o pulses exactly TIMEOUT cycles after the grant with resp_id_o=gnt_id and no resp_vld_o; a later late result is ignored.
REQ-042 Result on the last timeout cycle -> resp_vld_o pulses and err_o stays 0.
REQ-043 Reset mid-WAIT: rst_p pulses 5 cycles after a grant -> all outputs are 0, no response is issued, and the next grant starts from requester 0.
